// File: rtl/is_queue.sv
// is_queue: decode/issue stage with an instruction buffer between IF and REG/ROB.
//
// Fetched RV32I instructions are queued in a DEPTH-entry circular buffer.
// The head entry is decoded every cycle. It is loaded into the output register
// whenever that register is empty or its contents are being accepted. This means
// downstream back-pressure stalls the stream instead of dropping instructions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  global ready; 0 freezes every register
//   flush               discards buffer contents and the output register
//   if_valid/if_ready   IF handshake; if_ins/if_bj/if_pc/if_pjt form the payload
//   iss_valid/iss_ready issue handshake toward REG/ROB
//   iss_rs1/rs2/rd      register fields; fields the format does not use are 0
//   iss_op              inner opcode (0 = invalid); iss_imm is the sign-extended immediate
//   iss_pc/iss_pjt      passed through from IF
//   iss_ils/iss_is/iss_bj  load-or-store / is-store / branch-jump flags
//   iss_illegal         unrecognised opcode or funct3
//   count               buffer occupancy (the output register is not counted)
module is_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OP_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [31:0]                if_ins,
    input  logic                       if_bj,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            if_pjt,
    output logic                       if_ready,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [4:0]                 iss_rs1,
    output logic [4:0]                 iss_rs2,
    output logic [4:0]                 iss_rd,
    output logic [OP_W-1:0]            iss_op,
    output logic [XLEN-1:0]            iss_imm,
    output logic [XLEN-1:0]            iss_pc,
    output logic [XLEN-1:0]            iss_pjt,
    output logic                       iss_ils,
    output logic                       iss_is,
    output logic                       iss_bj,
    output logic                       iss_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]     mem_ins [DEPTH];
    logic            mem_bj  [DEPTH];
    logic [XLEN-1:0] mem_pc  [DEPTH];
    logic [XLEN-1:0] mem_pjt [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    logic [31:0]     h_ins;
    logic [2:0]      f3;
    logic [OP_W-1:0] d_op;
    logic [4:0]      d_rd, d_rs1, d_rs2;
    logic [31:0]     imm32;
    logic            d_ils, d_is, d_ill;

    assign if_ready = en & ~flush & (count != CW'(DEPTH));
    assign push     = if_valid & if_ready;
    assign pop      = en & ~flush & (count != '0) & (~iss_valid | iss_ready);

    assign h_ins = mem_ins[rd_ptr];
    assign f3    = h_ins[14:12];

    always_comb begin
        d_op  = '0;
        d_rd  = h_ins[11:7];
        d_rs1 = h_ins[19:15];
        d_rs2 = h_ins[24:20];
        imm32 = '0;
        d_ils = 1'b0;
        d_is  = 1'b0;
        d_ill = 1'b0;
        case (h_ins[6:0])
            7'b0110111, 7'b0010111: begin  // LUI / AUIPC
                d_op  = (h_ins[5]) ? OP_W'(1) : OP_W'(2);
                imm32 = {h_ins[31:12], 12'b0};
                d_rs1 = '0;
                d_rs2 = '0;
            end
            7'b1101111: begin  // JAL
                d_op  = OP_W'(3);
                imm32 = {{11{h_ins[31]}}, h_ins[31], h_ins[19:12], h_ins[20], h_ins[30:21], 1'b0};
                d_rs1 = '0;
                d_rs2 = '0;
            end
            7'b1100111: begin  // JALR
                d_op  = OP_W'(4);
                imm32 = {{20{h_ins[31]}}, h_ins[31:20]};
                d_rs2 = '0;
                d_ill = (f3 != 3'b000);
            end
            7'b1100011: begin  // branches
                imm32 = {{19{h_ins[31]}}, h_ins[31], h_ins[7], h_ins[30:25], h_ins[11:8], 1'b0};
                d_rd  = '0;
                case (f3)
                    3'b000:  d_op = OP_W'(5);
                    3'b001:  d_op = OP_W'(6);
                    3'b100:  d_op = OP_W'(7);
                    3'b101:  d_op = OP_W'(8);
                    3'b110:  d_op = OP_W'(9);
                    3'b111:  d_op = OP_W'(10);
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0000011: begin  // loads
                imm32 = {{20{h_ins[31]}}, h_ins[31:20]};
                d_rs2 = '0;
                d_ils = 1'b1;
                case (f3)
                    3'b000:  d_op = OP_W'(1);
                    3'b001:  d_op = OP_W'(2);
                    3'b010:  d_op = OP_W'(3);
                    3'b100:  d_op = OP_W'(4);
                    3'b101:  d_op = OP_W'(5);
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0100011: begin  // stores
                imm32 = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
                d_rd  = '0;
                d_ils = 1'b1;
                d_is  = 1'b1;
                case (f3)
                    3'b000:  d_op = OP_W'(6);
                    3'b001:  d_op = OP_W'(7);
                    3'b010:  d_op = OP_W'(8);
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0010011: begin  // OP-IMM
                imm32 = {{20{h_ins[31]}}, h_ins[31:20]};
                d_rs2 = '0;
                case (f3)
                    3'b000:  d_op = OP_W'(11);
                    3'b001:  d_op = OP_W'(12);
                    3'b010:  d_op = OP_W'(13);
                    3'b011:  d_op = OP_W'(14);
                    3'b100:  d_op = OP_W'(15);
                    3'b101:  d_op = h_ins[30] ? OP_W'(17) : OP_W'(16);
                    3'b110:  d_op = OP_W'(18);
                    default: d_op = OP_W'(19);
                endcase
            end
            7'b0110011: begin  // OP (register-register)
                case (f3)
                    3'b000:  d_op = h_ins[30] ? OP_W'(21) : OP_W'(20);
                    3'b001:  d_op = OP_W'(22);
                    3'b010:  d_op = OP_W'(23);
                    3'b011:  d_op = OP_W'(24);
                    3'b100:  d_op = OP_W'(25);
                    3'b101:  d_op = h_ins[30] ? OP_W'(27) : OP_W'(26);
                    3'b110:  d_op = OP_W'(28);
                    default: d_op = OP_W'(29);
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal encodings still forward the raw register fields.
        if (d_ill) begin
            d_op  = '0;
            imm32 = '0;
            d_ils = 1'b0;
            d_is  = 1'b0;
            d_rd  = h_ins[11:7];
            d_rs1 = h_ins[19:15];
            d_rs2 = h_ins[24:20];
        end
    end

    // Storage has no reset; entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ins[wr_ptr] <= if_ins;
            mem_bj[wr_ptr]  <= if_bj;
            mem_pc[wr_ptr]  <= if_pc;
            mem_pjt[wr_ptr] <= if_pjt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            iss_valid   <= 1'b0;
            iss_op      <= '0;
            iss_rd      <= '0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
            iss_pjt     <= '0;
            iss_ils     <= 1'b0;
            iss_is      <= 1'b0;
            iss_bj      <= 1'b0;
            iss_illegal <= 1'b0;
        end else if (en) begin
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                iss_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr      <= rd_ptr + AW'(1);
                    iss_valid   <= 1'b1;
                    iss_op      <= d_op;
                    iss_rd      <= d_rd;
                    iss_rs1     <= d_rs1;
                    iss_rs2     <= d_rs2;
                    iss_imm     <= XLEN'($signed(imm32));
                    iss_pc      <= mem_pc[rd_ptr];
                    iss_pjt     <= mem_pjt[rd_ptr];
                    iss_ils     <= d_ils;
                    iss_is      <= d_is;
                    iss_bj      <= mem_bj[rd_ptr];
                    iss_illegal <= d_ill;
                end else if (iss_ready) begin
                    iss_valid <= 1'b0;
                end
                if (push && !pop)      count <= count + CW'(1);
                else if (!push && pop) count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_is_queue.sv
module tb_is_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_ins = '0;
    logic        if_bj = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_pjt = '0;
    logic        if_ready;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic [4:0]  iss_op;
    logic [31:0] iss_imm, iss_pc, iss_pjt;
    logic        iss_ils, iss_is, iss_bj, iss_illegal;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    is_queue #(.DEPTH(4), .XLEN(32), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .if_valid(if_valid), .if_ins(if_ins), .if_bj(if_bj), .if_pc(if_pc), .if_pjt(if_pjt),
        .if_ready(if_ready), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_op(iss_op),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_pjt(iss_pjt),
        .iss_ils(iss_ils), .iss_is(iss_is), .iss_bj(iss_bj), .iss_illegal(iss_illegal),
        .count(count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ADDI xk, x0, k
    function automatic logic [31:0] mk(input int k);
        logic [11:0] i12;
        logic [4:0]  r5;
        i12 = 12'(k);
        r5  = 5'(k);
        return {i12, 5'd0, 3'b000, r5, 7'b0010011};
    endfunction

    task automatic test_reset();
        step();
        step();
        total++;
        if ({iss_valid, count, iss_op, iss_rd, iss_imm, iss_pc, if_ready} !== {1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%b cnt=%0d op=%0d rd=%0d imm=%h pc=%h rdy=%b want v=0 cnt=0 op=0 rd=0 imm=0 pc=0 rdy=1",
                     iss_valid, count, iss_op, iss_rd, iss_imm, iss_pc, if_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [31:0] v_ins [9] = '{32'hFFF00093, 32'hFE20AE23, 32'h402081B3, 32'h002081B3, 32'h00000000,
                                   32'h123452B7, 32'hFE208EE3, 32'h0081A203, 32'h008000EF};
        logic [4:0]  v_op  [9] = '{5'd11, 5'd8, 5'd21, 5'd20, 5'd0, 5'd1, 5'd5, 5'd3, 5'd3};
        logic [4:0]  v_rd  [9] = '{5'd1, 5'd0, 5'd3, 5'd3, 5'd0, 5'd5, 5'd0, 5'd4, 5'd1};
        logic [4:0]  v_rs1 [9] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd3, 5'd0};
        logic [4:0]  v_rs2 [9] = '{5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
        logic [31:0] v_imm [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0,
                                   32'h12345000, 32'hFFFFFFFC, 32'h8, 32'h8};
        logic [2:0]  v_fl  [9] = '{3'b000, 3'b110, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000};
        logic [74:0] got, exp;
        iss_ready = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                if_valid = 1'b1;
                if_ins   = v_ins[i];
                if_pc    = 32'h1000 + 32'(4 * i);
                if_pjt   = 32'h2000 + 32'(i);
                if_bj    = (i == 6);
            end else begin
                if_valid = 1'b0;
            end
            step();
            total++;
            if (i == 0) begin
                if ({iss_valid, count} !== {1'b0, 3'd1}) begin
                    bad++;
                    $display("FAIL decode_latency: got v=%b cnt=%0d want v=0 cnt=1", iss_valid, count);
                end
            end else begin
                got = {iss_valid, iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_ils, iss_is, iss_illegal,
                       iss_bj, iss_pc[15:0]};
                exp = {1'b1, v_op[i-1], v_rd[i-1], v_rs1[i-1], v_rs2[i-1], v_imm[i-1], v_fl[i-1],
                       (i - 1 == 6), 16'h1000 + 16'(4 * (i - 1))};
                if (got !== exp || iss_pjt !== 32'h2000 + 32'(i - 1)) begin
                    bad++;
                    $display("FAIL decode_%0d: got %h pjt=%h want %h pjt=%h", i - 1, got, iss_pjt, exp,
                             32'h2000 + 32'(i - 1));
                end
            end
        end
        if_bj = 1'b0;
        step();
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL decode_drain: got v=%b cnt=%0d want v=0 cnt=0", iss_valid, count);
        end
    endtask

    task automatic test_full_drain();
        int acc = 0;
        iss_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if_valid = 1'b1;
            if_ins   = mk(k);
            if_pc    = 32'(k);
            if (if_ready) acc++;
            step();
        end
        if_valid = 1'b0;
        total++;
        if ({acc[3:0], count, if_ready, iss_valid, iss_imm} !== {4'd5, 3'd4, 1'b0, 1'b1, 32'd1}) begin
            bad++;
            $display("FAIL full_stall: got acc=%0d cnt=%0d rdy=%b v=%b imm=%0d want acc=5 cnt=4 rdy=0 v=1 imm=1",
                     acc, count, if_ready, iss_valid, iss_imm);
        end
        iss_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            total++;
            if ({iss_valid, iss_imm, iss_rd, count} !== {1'b1, 32'(k), 5'(k), 3'(5 - k)}) begin
                bad++;
                $display("FAIL drain_%0d: got v=%b imm=%0d rd=%0d cnt=%0d want v=1 imm=%0d rd=%0d cnt=%0d",
                         k, iss_valid, iss_imm, iss_rd, count, k, k, 5 - k);
            end
            step();
        end
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0", iss_valid, count);
        end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if_valid = 1'b1;
            if_ins   = mk(k);
            step();
        end
        total++;
        if ({iss_valid, count, iss_imm} !== {1'b1, 3'd3, 32'd1}) begin
            bad++;
            $display("FAIL flush_setup: got v=%b cnt=%0d imm=%0d want v=1 cnt=3 imm=1", iss_valid, count, iss_imm);
        end
        flush  = 1'b1;
        if_ins = mk(9);
        #1;
        total++;
        if (if_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got %b want 0", if_ready);
        end
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL flush_clear: got v=%b cnt=%0d want v=0 cnt=0", iss_valid, count);
        end
        step();
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL flush_dropped: got v=%b cnt=%0d want v=0 cnt=0", iss_valid, count);
        end
        if_valid = 1'b1;
        if_ins   = mk(7);
        step();
        if_valid = 1'b0;
        step();
        total++;
        if ({iss_valid, iss_imm, count} !== {1'b1, 32'd7, 3'd0}) begin
            bad++;
            $display("FAIL flush_resume: got v=%b imm=%0d cnt=%0d want v=1 imm=7 cnt=0", iss_valid, iss_imm, count);
        end
        iss_ready = 1'b1;
        step();
    endtask

    task automatic test_en_hold();
        iss_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if_valid = 1'b1;
            if_ins   = mk(k);
            step();
        end
        en        = 1'b0;
        iss_ready = 1'b1;
        if_ins    = mk(8);
        flush     = 1'b1;
        #1;
        total++;
        if (if_ready !== 1'b0) begin
            bad++;
            $display("FAIL en_ready: got %b want 0", if_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({iss_valid, iss_imm, iss_rd, count} !== {1'b1, 32'd1, 5'd1, 3'd2}) begin
                bad++;
                $display("FAIL en_hold_%0d: got v=%b imm=%0d rd=%0d cnt=%0d want v=1 imm=1 rd=1 cnt=2",
                         c, iss_valid, iss_imm, iss_rd, count);
            end
        end
        en       = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        step();
        total++;
        if ({iss_valid, iss_imm, count} !== {1'b1, 32'd2, 3'd1}) begin
            bad++;
            $display("FAIL en_resume: got v=%b imm=%0d cnt=%0d want v=1 imm=2 cnt=1", iss_valid, iss_imm, count);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({iss_valid, count, iss_op, iss_rd, iss_imm, iss_pc} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%b cnt=%0d op=%0d rd=%0d imm=%h pc=%h want all 0",
                     iss_valid, count, iss_op, iss_rd, iss_imm, iss_pc);
        end
        step();
        rst_n = 1'b1;
        iss_ready = 1'b1;
        if_valid = 1'b1;
        if_ins   = mk(3);
        step();
        if_valid = 1'b0;
        step();
        total++;
        if ({iss_valid, iss_imm, count} !== {1'b1, 32'd3, 3'd0}) begin
            bad++;
            $display("FAIL post_reset: got v=%b imm=%0d cnt=%0d want v=1 imm=3 cnt=0", iss_valid, iss_imm, count);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_full_drain();
        test_flush();
        test_en_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
